// File: rtl/console_pkg.sv
// console_pkg
// Shared definitions for the console output path.
//   ASCII_CR / ASCII_LF : line-break characters, reused by other console blocks
//   arb_state_t         : sequencer states of console_tx_arbiter
package console_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      EOL_CR,
      EOL_LF
   } arb_state_t;

endpackage

// File: rtl/console_tx_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Grants the first requester strictly
// after the last owner, wrapping around. The owner register lives in the
// parent.
//   req  : request vector
//   last : one-hot last owner
//   gnt  : one-hot pick, zero when no request
module rr_arbiter
   import console_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] gnt
);

   logic [N-1:0] above;
   logic [N-1:0] hi_req;
   logic [N-1:0] sel;

   always_comb begin
      // Bits strictly above the last owner. When the last owner is the top
      // bit the shift wraps to zero and the mask is empty, so the search
      // falls back to the full request vector.
      above  = ~((last << 1) - N'(1));
      hi_req = req & above;
      sel    = (hi_req != '0) ? hi_req : req;
      // Keep only the lowest set bit.
      gnt    = sel & (~sel + N'(1));
   end

endmodule

// File: rtl/console_tx_arbiter.sv
// console_tx_arbiter
// Shares the single console transmit byte port between N_SRC message
// sources. A source owns the channel from its grant until its final byte
// (plus any trailing line break) has been loaded. Line breaks are emitted
// as CR LF (EOL_CRLF=1) or LF only (EOL_CRLF=0).
//   clk, rst_n   : clock, synchronous active-low reset
//   src_req      : per-source message request (sampled only when idle)
//   src_data     : byte of source i at [8i+7:8i]
//   src_valid    : per-source byte valid
//   src_last     : byte is the last of the message
//   src_nl       : append a line break after this byte
//   src_ready    : per-source byte accept strobe (with src_valid)
//   grant        : one-hot channel owner, zero when idle
//   tx_data/tx_valid/tx_ready : single-entry output register to the UART
//   busy         : sequencer active or output byte pending
module console_tx_arbiter
   import console_pkg::*;
#(
   parameter int N_SRC    = 2,
   parameter bit EOL_CRLF = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_SRC-1:0]     src_req,
   input  logic [8*N_SRC-1:0]   src_data,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [N_SRC-1:0]     src_last,
   input  logic [N_SRC-1:0]     src_nl,
   output logic [N_SRC-1:0]     src_ready,
   output logic [N_SRC-1:0]     grant,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy
);

   localparam logic [N_SRC-1:0] OWNER_RST = {1'b1, {(N_SRC-1){1'b0}}};

   arb_state_t       state;
   logic [N_SRC-1:0] owner;      // one-hot last owner
   logic [N_SRC-1:0] pick;
   logic             last_pend;  // last accepted byte closed the message
   logic             can_load;
   logic             accept;
   logic             valid_g;
   logic             nl_g;
   logic             last_g;
   logic [7:0]       data_g;

   rr_arbiter #(.N(N_SRC)) u_rr (
      .req  (src_req),
      .last (owner),
      .gnt  (pick)
   );

   // Fields of the granted source; grant is one-hot so masking selects it.
   always_comb begin
      data_g = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) data_g = src_data[8*i +: 8];
      end
   end

   assign valid_g   = |(src_valid & grant);
   assign nl_g      = |(src_nl & grant);
   assign last_g    = |(src_last & grant);

   // Output register can take a new byte when empty or draining this cycle.
   assign can_load  = tx_ready | ~tx_valid;
   assign src_ready = (state == STREAM && can_load) ? grant : '0;
   assign accept    = (state == STREAM) & can_load & valid_g;
   assign busy      = (state != IDLE) | tx_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         owner     <= OWNER_RST;
         last_pend <= 1'b0;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
      end else begin
         // Drain; any load below in the same cycle overrides this.
         if (tx_ready) tx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (|src_req) begin
                  grant <= pick;
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (accept) begin
                  tx_data   <= data_g;
                  tx_valid  <= 1'b1;
                  last_pend <= last_g;
                  // A line break takes priority; release happens after LF.
                  if (nl_g) begin
                     state <= EOL_CRLF ? EOL_CR : EOL_LF;
                  end else if (last_g) begin
                     state <= IDLE;
                     grant <= '0;
                     owner <= grant;
                  end
               end
            end
            EOL_CR: begin
               if (can_load) begin
                  tx_data  <= ASCII_CR;
                  tx_valid <= 1'b1;
                  state    <= EOL_LF;
               end
            end
            EOL_LF: begin
               if (can_load) begin
                  tx_data  <= ASCII_LF;
                  tx_valid <= 1'b1;
                  if (last_pend) begin
                     state <= IDLE;
                     grant <= '0;
                     owner <= grant;
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
